// File: rtl/riscv_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU/immediate/result selector codes and width defaults.
package riscv_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file with x0 hardwired to zero and write-through read bypass.
module reg_file
    import riscv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_en;

    assign wr_en = we_i && (wa_i != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // A writeback landing this cycle is forwarded so the consumer being decoded sees it.
    always_comb begin
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (wr_en && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end else begin
            rd1_o = regs_q[ra1_i];
        end
    end

    always_comb begin
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (wr_en && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end else begin
            rd2_o = regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: RV32I control decode, immediate extension, register read and the ID/EX pipeline register.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       InstrD,
    input  logic [31:0]       PCD,
    input  logic [31:0]       PCPlus4D,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [DATA_W-1:0] ResultW,
    output logic [REG_AW-1:0] Rs1D,
    output logic [REG_AW-1:0] Rs2D,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic              ALUSrcE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E
);

    typedef struct packed {
        logic              reg_write;
        result_src_e       result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        alu_ctl_e          alu_ctl;
        logic              alu_src;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [31:0]       pc;
        logic [31:0]       pcp4;
    } idex_t;

    idex_t idex_d, idex_q;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic              reg_write;
    result_src_e       result_src;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    imm_src_e          imm_src;
    alu_op_e           alu_op;
    alu_ctl_e          alu_ctl;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7_5 = InstrD[30];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    always_comb begin
        reg_write  = 1'b0;
        result_src = RES_ALU;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                imm_src   = IMM_S;
                alu_src   = 1'b1;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            default: ;
        endcase
    end

    // funct7[5] selects sub only for register-register ops; addi with bit 30 set is still add.
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_ctl = (opcode == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b110:  alu_ctl = ALU_OR;
                    3'b111:  alu_ctl = ALU_AND;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        case (imm_src)
            IMM_S:   imm_ext = {{(DATA_W-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{(DATA_W-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   imm_ext = {{(DATA_W-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext = {{(DATA_W-12){InstrD[31]}}, InstrD[31:20]};
        endcase
    end

    reg_file #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_reg_file (
        .clk    (clk),
        .resetn (resetn),
        .ra1_i  (Rs1D),
        .ra2_i  (Rs2D),
        .we_i   (RegWriteW),
        .wa_i   (RdW),
        .wd_i   (ResultW),
        .rd1_o  (rd1),
        .rd2_o  (rd2)
    );

    always_comb begin
        idex_d            = '0;
        idex_d.reg_write  = reg_write;
        idex_d.result_src = result_src;
        idex_d.mem_write  = mem_write;
        idex_d.jump       = jump;
        idex_d.branch     = branch;
        idex_d.alu_ctl    = alu_ctl;
        idex_d.alu_src    = alu_src;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.imm        = imm_ext;
        idex_d.rs1        = Rs1D;
        idex_d.rs2        = Rs2D;
        idex_d.rd         = InstrD[11:7];
        idex_d.pc         = PCD;
        idex_d.pcp4       = PCPlus4D;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign ResultSrcE  = idex_q.result_src;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUControlE = idex_q.alu_ctl;
    assign ALUSrcE     = idex_q.alu_src;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pcp4;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: directed plus random instructions against a behavioural decode model.
module tb_decode_cycle;

    logic        clk;
    logic        resetn;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluctl;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } exp_t;

    exp_t        act;
    exp_t        q[$];
    logic [31:0] mem [32];
    int          checks = 0;
    int          errors = 0;
    int          pushes = 0;
    int          pops   = 0;

    assign act = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                  RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E};

    decode_cycle dut (
        .clk(clk), .resetn(resetn), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decode: each instruction class states its own control tuple and immediate.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] pcp4,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [31:0] imm_i, imm_s, imm_b, imm_j;
        imm_i = $unsigned($signed(i) >>> 20);
        imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e = '0;
        e.rd1 = r1; e.rd2 = r2; e.imm = imm_i;
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.pc = pc; e.pcp4 = pcp4;
        case (i[6:0])
            7'h03: begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 2'b01; end
            7'h23: begin e.memwrite = 1; e.alusrc = 1; e.imm = imm_s; end
            7'h63: begin e.branch = 1; e.aluctl = 3'b001; e.imm = imm_b; end
            7'h6F: begin e.regwrite = 1; e.jump = 1; e.resultsrc = 2'b10; e.imm = imm_j; end
            7'h33, 7'h13: begin
                e.regwrite = 1;
                e.alusrc   = (i[6:0] == 7'h13);
                if (i[14:12] == 3'b010)      e.aluctl = 3'b101;
                else if (i[14:12] == 3'b110) e.aluctl = 3'b011;
                else if (i[14:12] == 3'b111) e.aluctl = 3'b010;
                else if (i[14:12] == 3'b000 && i[6:0] == 7'h33 && i[30]) e.aluctl = 3'b001;
                else                         e.aluctl = 3'b000;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        resetn = 1'b1; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        FlushE = flush; RegWriteW = we; RdW = wa; ResultW = wd;
        e = model(instr, pc, pc + 32'd4, rd_model(instr[19:15], we, wa, wd),
                  rd_model(instr[24:20], we, wa, wd));
        if (flush) e = '0;
        q.push_back(e);
        pushes++;
        if (we && wa != 0) mem[wa] = wd;
        #1;
        checks++;
        if (Rs1D !== instr[19:15] || Rs2D !== instr[24:20]) begin
            errors++;
            $display("FAIL rs_comb instr=%h act rs1=%0d rs2=%0d exp rs1=%0d rs2=%0d",
                     instr, Rs1D, Rs2D, instr[19:15], instr[24:20]);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        resetn = 1'b0; FlushE = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h99;
        #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s act=%h exp=0", name, act);
        end
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
        @(negedge clk);
        RegWriteW = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                pops++;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL idex pc=%h act=%h exp=%h", e.pc, act, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout pushes=%0d pops=%0d", pushes, pops);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] ins;
        logic [4:0]  wa;
        logic        we, fl;
        int          sel;
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
        resetn = 1'b1; InstrD = 0; PCD = 0; PCPlus4D = 0;
        FlushE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
        #1 resetn = 1'b0;
        do_reset("reset_state");

        drive(32'h00500093, 32'h100, 0, 0, 0, 0);                 // addi x1,x0,5
        drive(32'h002081B3, 32'h104, 0, 1, 5'd2, 32'hDEADBEEF);   // add x3,x1,x2 with bypass
        drive(32'h00500093, 32'h108, 0, 1, 5'd0, 32'h12345678);   // write to x0 dropped
        drive(32'h00000133, 32'h10C, 0, 0, 0, 0);                 // add x2,x0,x0 reads x0
        drive(32'hFE000EE3, 32'h110, 0, 0, 0, 0);                 // beq x0,x0,-4
        drive(32'h0080006F, 32'h100, 0, 0, 0, 0);                 // jal x0,8, PCPlus4D=0x104
        drive(32'h0000A103, 32'h118, 1, 0, 0, 0);                 // lw flushed
        drive(32'h00000000, 32'h11C, 0, 0, 0, 0);                 // zero instr bubble
        drive(32'h40208233, 32'h120, 0, 0, 0, 0);                 // sub x4,x1,x2
        drive(32'h40208213, 32'h124, 0, 0, 0, 0);                 // addi with bit30 set stays add
        drive(32'h00000013, 32'h128, 0, 1, 5'd5, 32'h7);          // write x5=7
        drive(32'h00028093, 32'h12C, 0, 0, 0, 0);                 // read x5
        do_reset("reset_async");
        drive(32'h00028093, 32'h130, 0, 0, 0, 0);                 // x5 cleared by reset

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 8);
            ins = $urandom;
            case (sel)
                0: ins[6:0] = 7'h03;
                1: ins[6:0] = 7'h23;
                2, 8: ins[6:0] = 7'h33;
                3: ins[6:0] = 7'h13;
                4: ins[6:0] = 7'h63;
                5: ins[6:0] = 7'h6F;
                6: ins = 32'h0;
                default: ;
            endcase
            we = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: wa = ins[19:15];
                1: wa = ins[24:20];
                default: wa = 5'($urandom);
            endcase
            fl = ($urandom_range(0, 7) == 0);
            drive(ins, $urandom & 32'hFFFF_FFFC, fl, we, wa, $urandom);
            if (n == 200) do_reset("reset_mid_random");
        end

        @(negedge clk);
        RegWriteW = 0; FlushE = 0;
        @(negedge clk);
        checks++;
        if (q.size() != 0 || pushes != pops) begin
            errors++;
            $display("FAIL drain act pops=%0d left=%0d exp pops=%0d left=0", pops, q.size(), pushes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Consumer side of the IF/ID pipeline register. Takes InstrD, PCD and PCPlus4D from the fetch stage.
- Decodes RV32I control, extends immediates and reads the register file.
- Captures everything into the ID/EX pipeline register for the execute stage.
- Also hosts the writeback port of the register file and exports Rs1D/Rs2D to the hazard unit.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width (2**REG_AW registers)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- InstrD  in  32  instruction from IF/ID register
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PC+4 of InstrD
- FlushE  in  1  synchronous clear of ID/EX register (bubble insert)
- RegWriteW  in  1  writeback enable
- RdW  in  REG_AW  writeback destination
- ResultW  in  DATA_W  writeback data
- Rs1D  out  REG_AW  InstrD[19:15], combinational, to hazard unit
- Rs2D  out  REG_AW  InstrD[24:20], combinational, to hazard unit
- RegWriteE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1  store enable
- JumpE  out  1  jal
- BranchE  out  1  beq
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcE  out  1  1 = immediate operand
- RD1E  out  DATA_W  rs1 value
- RD2E  out  DATA_W  rs2 value
- ImmExtE  out  DATA_W  sign-extended immediate
- Rs1E  out  REG_AW  rs1 address
- Rs2E  out  REG_AW  rs2 address
- RdE  out  REG_AW  InstrD[11:7]
- PCE  out  32  registered PCD
- PCPlus4E  out  32  registered PCPlus4D

Behaviour:
- Reset:
  - Every registered output and every register-file entry clears to 0 on resetn low, asynchronously.
  - Reset mid-operation discards any pending writeback.
- Latency: one cycle. ID/EX outputs reflect the InstrD present at the previous posedge.
- ID/EX register priority:
  - resetn low: clear.
  - Else FlushE high: all outputs clear to 0, i.e. a bubble with no RegWrite/MemWrite/Branch/Jump.
  - Else load.
  - No stall input: decode never holds, because a stalled IF/ID presents the same InstrD again.
- Main decoder (opcode InstrD[6:0]):
  - 0000011 lw: RegWrite=1, ImmSrc I, ALUSrc=1, ResultSrc=01, ALUOp=00.
  - 0100011 sw: MemWrite=1, ImmSrc S, ALUSrc=1, ALUOp=00.
  - 0110011 R-type: RegWrite=1, ALUOp=10.
  - 0010011 I-ALU: RegWrite=1, ImmSrc I, ALUSrc=1, ALUOp=10.
  - 1100011 beq: Branch=1, ImmSrc B, ALUOp=01.
  - 1101111 jal: RegWrite=1, Jump=1, ImmSrc J, ResultSrc=10.
  - Any other opcode, including 0x00000000 produced by a fetch flush: all controls 0, i.e. behaves as a bubble.
- ALU decoder:
  - ALUOp 00 gives add; 01 gives sub.
  - ALUOp 10 with funct3: 000 gives sub only if opcode is R-type and funct7[5]=1, else add; 010 slt; 110 or; 111 and.
  - Any other funct3 gives add.
- Immediate extension, sign bit always InstrD[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - When ImmSrc is unused the value is don't-care but must be deterministic; use I format.
- Register file:
  - 2 async read ports, 1 write port written at posedge when RegWriteW=1 and RdW≠0.
  - x0 always reads 0, and writes to x0 are dropped.
  - Write-through bypass: if RegWriteW=1, RdW≠0 and RdW equals the read address, the read port returns ResultW in the same cycle. This covers a writeback in the same cycle as the decode of a consumer.
- Simultaneous writeback and FlushE: the write still commits; only ID/EX clears.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants;
  - ALUControl, ALUOp, ImmSrc and ResultSrc encodings;
  - DATA_W/REG_AW defaults.
- One sub-module, reg_file: 2R1W, async reset, x0 hardwiring and write-through bypass.
- Decoders and the immediate extender stay as combinational logic inside decode_cycle.

Test Plan:
1. Reset, then InstrD=0x00500093 (addi x1,x0,5) -> next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, RD1E=0.
2. RegWriteW=1, RdW=2, ResultW=0xDEADBEEF, with InstrD=0x002081B3 (add x3,x1,x2) in the same cycle -> RD2E=0xDEADBEEF via bypass. Writeback to RdW=0 with a read of x0 -> RD1E=0.
3. InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
4. InstrD=0x0080006F (jal x0,8) with PCPlus4D=0x104 -> JumpE=1, ResultSrcE=10, ImmExtE=8, PCPlus4E=0x104.
5. Valid lw (0x0000A103) with FlushE=1 -> all ID/EX outputs 0 next cycle. InstrD=0x00000000 without flush -> all controls 0.
6. Assert resetn low mid-stream after writing x5=7 -> outputs 0 immediately; after release, reading x5 returns 0.
